operand_feeder: RTL
===================

// Module: operand_feeder
// PURPOSE
//  Upstream/downstream wrapper for one composition/operation core (ST/RD handshake, flat operand inputs).
//  - Collects ICNT operand words from a valid/ready stream and presents them on OP_IN.
//  - Pulses OP_ST, waits for OP_RD, captures OP_RES and forwards it on a valid/ready result stream.
//  - Applies a watchdog: a hung core is reset and an error result is emitted.
// PARAMETERS
//  BW       16   operand/result width in bits
//  ICNT     2    operands per operation (1..8)
//  TIMEOUT  256  max cycles waiting for OP_RD before abort (>=4)
// PORTS
//  CLK      in   1         clock; all logic on rising edge
//  RST      in   1         asynchronous, active-low reset (RST=0 resets)
//  S_DATA   in   BW        operand word
//  S_VALID  in   1         operand word valid
//  S_READY  out  1         feeder accepts word (transfer = S_VALID & S_READY)
//  OP_RST   out  1         active-high reset to core
//  OP_ST    out  1         start pulse to core
//  OP_RD    in   1         core done (level; may persist after completion)
//  OP_RES   in   BW        core result, valid while OP_RD=1
//  OP_IN    out  ICNT*BW   operands; word i at [i*BW +: BW]
//  M_DATA   out  BW        result word
//  M_ERR    out  1         result is a timeout abort (M_DATA=0)
//  M_VALID  out  1         result valid
//  M_READY  in   1         consumer accepts (transfer = M_VALID & M_READY)
// BEHAVIOUR
//  Reset (RST=0): state=COLLECT, idx=0, OP_IN=0, OP_ST=0, OP_RST=1, M_VALID=0, M_DATA=0, M_ERR=0, S_READY=0.
//   OP_RST deasserts on first clock edge after RST rises; S_READY=1 from the following cycle.
//  FSM states: COLLECT, START, WAIT, OUTPUT, ABORT.
//  COLLECT: S_READY=1; each transfer writes OP_IN word idx, idx++. Transfer with idx=ICNT-1 -> START, idx=0.
//  START: one cycle; OP_ST=1 exactly this cycle; OP_IN frozen from here until OUTPUT/ABORT exits. -> WAIT.
//  WAIT: OP_RD sampled only here (RD during START ignored: stale done from previous op).
//   OP_RD=1 -> M_DATA<=OP_RES, M_ERR<=0, M_VALID<=1, -> OUTPUT. Latency START->M_VALID >= 2 cycles.
//   Watchdog counts cycles in WAIT; count reaches TIMEOUT-1 with OP_RD=0 -> ABORT.
//  ABORT: OP_RST=1 for exactly 2 cycles; then M_DATA=0, M_ERR=1, M_VALID=1 -> OUTPUT.
//  OUTPUT: M_VALID/M_DATA/M_ERR held stable until M_READY=1; on transfer M_VALID=0 same edge -> COLLECT.
//   S_READY=0 in OUTPUT (no overlap; one operation in flight).
//  Simultaneous: OP_RD=1 on the timeout cycle -> result wins (no abort).
//  Words presented when S_READY=0 are not consumed; S_DATA sampled only on transfer.
//  Reset mid-operation: all state discarded, partial operand set lost, OP_RST=1 asserted to core.
//  Watchdog counter width $clog2(TIMEOUT); cleared on WAIT entry.
// STRUCTURE
//  Shared package: FSM state encoding (S_COLLECT..S_ABORT, 3 bits), ABORT_RST_CYCLES=2.
//  One natural sub-module: feeder_watchdog (clear/enable in, expire out, TIMEOUT parameter).
//  Operand register file and result register inline.
// TESTING
//  - Feed 4,5 to addition core (BW=16,ICNT=2) -> one OP_ST pulse, M_DATA=9, M_ERR=0, M_VALID held until M_READY.
//  - Pairs (1,2),(0xFFFF,1) back-to-back, M_READY=1 -> M_DATA 3 then 0x0000 (wrap), S_READY=0 between.
//  - M_READY=0 for 20 cycles after result -> M_DATA stable, S_READY=0, no new OP_ST.
//  - Stub core never raises OP_RD, TIMEOUT=8 -> OP_RST high 2 cycles, M_ERR=1, M_DATA=0.
//  - Core RD held high from prior op -> no capture during START; capture only on fresh WAIT RD.
//  - RST low during WAIT -> outputs at reset values, OP_RST=1; next pair 7,8 -> M_DATA=15.

Source files
------------

// File: rtl/operand_feeder_pkg.sv
// Shared definitions for the operand feeder:
// controller state encoding and abort timing.
package operand_feeder_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_COLLECT = 3'd0;
   localparam state_t S_START   = 3'd1;
   localparam state_t S_WAIT    = 3'd2;
   localparam state_t S_OUTPUT  = 3'd3;
   localparam state_t S_ABORT   = 3'd4;

   localparam int ABORT_RST_CYCLES = 2;

endpackage

// File: rtl/feeder_watchdog.sv
// Cycle watchdog for the core handshake:
// expires on the TIMEOUT-th enabled cycle after clear.
module feeder_watchdog #(
   parameter int TIMEOUT = 256
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && cnt_q != LAST) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/operand_feeder.sv
// Gathers ICNT operands, runs one core operation
// under a watchdog and forwards the result.
module operand_feeder
   import operand_feeder_pkg::*;
#(
   parameter int BW      = 16,
   parameter int ICNT    = 2,
   parameter int TIMEOUT = 256
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [BW-1:0]      S_DATA,
   input  logic               S_VALID,
   output logic               S_READY,
   output logic               OP_RST,
   output logic               OP_ST,
   input  logic               OP_RD,
   input  logic [BW-1:0]      OP_RES,
   output logic [ICNT*BW-1:0] OP_IN,
   output logic [BW-1:0]      M_DATA,
   output logic               M_ERR,
   output logic               M_VALID,
   input  logic               M_READY
);

   localparam int IW  = (ICNT > 1) ? $clog2(ICNT) : 1;
   localparam int ACW = 2;
   localparam logic [IW-1:0]  IDX_LAST = IW'(ICNT - 1);
   localparam logic [ACW-1:0] AB_LAST  = ACW'(ABORT_RST_CYCLES - 1);

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [ICNT*BW-1:0]  op_in_q, op_in_d;
   logic [BW-1:0]       m_data_q, m_data_d;
   logic                m_err_q, m_err_d;
   logic                m_valid_q, m_valid_d;
   logic [ACW-1:0]      ab_cnt_q, ab_cnt_d;
   logic                init_q;
   logic                wd_expire;

   feeder_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk_i    (CLK),
      .rst_ni   (RST),
      .clr_i    (state_q == S_START),
      .en_i     (state_q == S_WAIT),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      op_in_d   = op_in_q;
      m_data_d  = m_data_q;
      m_err_d   = m_err_q;
      m_valid_d = m_valid_q;
      ab_cnt_d  = ab_cnt_q;
      unique case (state_q)
         S_COLLECT: begin
            if (S_VALID && S_READY) begin
               for (int i = 0; i < ICNT; i++) begin
                  if (IW'(i) == idx_q) op_in_d[i*BW +: BW] = S_DATA;
               end
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = S_START;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_START: state_d = S_WAIT;
         S_WAIT: begin
            // A done level seen in START belongs to the previous op.
            if (OP_RD) begin
               m_data_d  = OP_RES;
               m_err_d   = 1'b0;
               m_valid_d = 1'b1;
               state_d   = S_OUTPUT;
            end else if (wd_expire) begin
               ab_cnt_d = '0;
               state_d  = S_ABORT;
            end
         end
         S_ABORT: begin
            if (ab_cnt_q == AB_LAST) begin
               m_data_d  = '0;
               m_err_d   = 1'b1;
               m_valid_d = 1'b1;
               state_d   = S_OUTPUT;
            end else begin
               ab_cnt_d = ab_cnt_q + ACW'(1);
            end
         end
         S_OUTPUT: begin
            if (M_READY) begin
               m_valid_d = 1'b0;
               state_d   = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_COLLECT;
         idx_q     <= '0;
         op_in_q   <= '0;
         m_data_q  <= '0;
         m_err_q   <= 1'b0;
         m_valid_q <= 1'b0;
         ab_cnt_q  <= '0;
         init_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         op_in_q   <= op_in_d;
         m_data_q  <= m_data_d;
         m_err_q   <= m_err_d;
         m_valid_q <= m_valid_d;
         ab_cnt_q  <= ab_cnt_d;
         init_q    <= 1'b0;
      end
   end

   assign S_READY = (state_q == S_COLLECT) && !init_q;
   assign OP_RST  = init_q || (state_q == S_ABORT);
   assign OP_ST   = (state_q == S_START);
   assign OP_IN   = op_in_q;
   assign M_DATA  = m_data_q;
   assign M_ERR   = m_err_q;
   assign M_VALID = m_valid_q;

endmodule
